im_port_arbiter: RTL and testbench

Sequences and shares the single port of the CPU instruction memory between a boot loader (write stream) and the fetch stage (read requests). After reset it owns the port for the loader until the last boot word is written, then grants it to fetch, returning read data with fixed two-cycle latency. It sits between the loader, the fetch unit and the instruction memory's `we_IM/address_IM/dataIM/out_IM` port.

---
 rtl/im_port_arbiter.sv | 136 +++++++++++++
 tb/tb_im_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_port_arbiter.sv
// Shares the instruction-memory port between the boot loader (writes) and fetch (reads).
// Optional build macro IM_ARB_RUNTIME_WRITE_EN lets the loader keep writing in RUN, arbitrated against fetch.
module im_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  input  logic                     fe_req,
  input  logic [ADDRESS_WIDTH-1:0] fe_addr,
  output logic                     fe_gnt,
  output logic                     fe_rvalid,
  output logic [DATA_WIDTH-1:0]    fe_rdata,
  output logic                     boot_done,
  output logic [ADDRESS_WIDTH:0]   ld_count,
  output logic                     im_we,
  output logic [ADDRESS_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0]    im_wdata,
  input  logic [DATA_WIDTH-1:0]    im_rdata
);

  // Handshake: a loader beat transfers in a cycle where ld_valid & ld_ready, a fetch
  // in a cycle where fe_req & fe_gnt; ready/grant never depend on the partner's data
  // and at most one of the two transfers happens per cycle.
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDRESS_WIDTH:0] CNT_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_t                   state_q, state_d;
  logic                     im_we_q;
  logic [ADDRESS_WIDTH-1:0] im_addr_q;
  logic [DATA_WIDTH-1:0]    im_wdata_q;
  logic                     rd_pend_q;
  logic                     fe_rvalid_q;
  logic [ADDRESS_WIDTH:0]   ld_count_q;
  logic                     ld_acc;
  logic                     fe_acc;

`ifdef IM_ARB_RUNTIME_WRITE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          force_fe;

  assign force_fe = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    ld_ready = 1'b0;
    fe_gnt   = 1'b0;
    if (!rst) begin
      case (state_q)
        BOOT: ld_ready = 1'b1;
        RUN: begin
          ld_ready = !force_fe;
          fe_gnt   = force_fe || !ld_valid;
        end
        default: ;
      endcase
    end
  end

  // Counts consecutive cycles in which the loader beat a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (state_q == RUN) begin
      if (!fe_req || fe_acc)
        starve_d = '0;
      else if (ld_acc)
        starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  always_comb begin
    ld_ready = 1'b0;
    fe_gnt   = 1'b0;
    if (!rst) begin
      ld_ready = (state_q == BOOT);
      fe_gnt   = (state_q == RUN);
    end
  end
`endif

  assign ld_acc = ld_valid & ld_ready;
  assign fe_acc = fe_req & fe_gnt;

  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && ld_acc && ld_last)
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      rd_pend_q   <= 1'b0;
      fe_rvalid_q <= 1'b0;
      ld_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      im_we_q     <= ld_acc;
      rd_pend_q   <= fe_acc;
      fe_rvalid_q <= rd_pend_q;
      if (ld_acc) begin
        im_addr_q  <= ld_addr;
        im_wdata_q <= ld_data;
      end else if (fe_acc) begin
        im_addr_q  <= fe_addr;
      end
      if (ld_acc && ld_count_q != CNT_MAX)
        ld_count_q <= ld_count_q + 1'b1;
    end
  end

  // The state register itself is the boot_done flag, so the FSM is directly observable.
  assign boot_done = (state_q == RUN);
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign fe_rvalid = fe_rvalid_q;
  assign fe_rdata  = im_rdata;
  assign ld_count  = ld_count_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a small synchronous memory behind the port.
module tb_im_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_ready, ld_last;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          fe_req, fe_gnt, fe_rvalid;
  logic [AW-1:0] fe_addr;
  logic [DW-1:0] fe_rdata;
  logic          boot_done;
  logic [AW:0]   ld_count;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata, im_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ld_tbl [3] = '{32'h11, 32'h22, 32'h33};
  int            n_vec = 0;
  int            n_err = 0;

  im_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid),
    .fe_rdata(fe_rdata), .boot_done(boot_done), .ld_count(ld_count),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_rdata(im_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory: registered read, write committed at the clock edge
  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_wdata;
    im_rdata <= mem[im_addr];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: every read response is matched against the expected queue
  always @(negedge clk) begin
    if (fe_rvalid) begin
      if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
      else                   check("rdata", fe_rdata, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    fe_req = 1'b0; fe_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    im_rdata = '0;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_ld_ready", ld_ready, 0);
    check("rst_fe_gnt", fe_gnt, 0);
    rst = 1'b0;
    #1;
    check("rel_ld_ready", ld_ready, 1);
    check("rel_fe_gnt", fe_gnt, 0);
    check("rel_im_we", im_we, 0);
    check("rel_im_addr", im_addr, 0);
    check("rel_boot_done", boot_done, 0);
    check("rel_ld_count", ld_count, 0);
    check("rel_rvalid", fe_rvalid, 0);

    // boot load of three words while fetch waits on address 1
    fe_req = 1'b1; fe_addr = 10'd1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = ld_tbl[i]; ld_last = (i == 2);
      #1;
      check("boot_fe_gnt", fe_gnt, 0);
      check("boot_ld_ready", ld_ready, 1);
      tick();
      check("ld_im_we", im_we, 1);
      check("ld_im_addr", im_addr, i);
      check("ld_im_wdata", im_wdata, ld_tbl[i]);
      check("ld_count", ld_count, i + 1);
      check("ld_boot_done", boot_done, i == 2);
    end
    idle_inputs();
    fe_req = 1'b1; fe_addr = 10'd1;
    #1;
    check("run_fe_gnt", fe_gnt, 1);
    check("run_ld_ready", ld_ready, 0);
    exp_q.push_back(32'h22);
    tick();
    fe_req = 1'b0;
    check("rd_im_we", im_we, 0);
    check("rd_im_addr", im_addr, 1);
    check("rd_rvalid_t1", fe_rvalid, 0);
    tick();
    check("rd_rvalid_t2", fe_rvalid, 1);
    check("rd_rdata_t2", fe_rdata, 32'h22);
    tick();
    check("rd_rvalid_t3", fe_rvalid, 0);

    // back-to-back fetches of addresses 0,1,2
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        fe_req = 1'b1; fe_addr = AW'(k);
        exp_q.push_back(ld_tbl[k]);
      end else begin
        fe_req = 1'b0;
      end
      tick();
      check("b2b_rvalid", fe_rvalid, (k >= 1 && k <= 3));
    end
    check("b2b_drain", exp_q.size(), 0);

`ifdef IM_ARB_RUNTIME_WRITE_EN
    // loader and fetch contend: four writes, then a forced fetch
    ld_valid = 1'b1; ld_addr = 10'd1; ld_data = 32'h99;
    fe_req = 1'b1; fe_addr = 10'd1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rw_ld_ready", ld_ready, (k % 5) != 4);
      check("rw_fe_gnt", fe_gnt, (k % 5) == 4);
      if ((k % 5) == 4) exp_q.push_back(32'h99);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();
    check("rw_drain", exp_q.size(), 0);
    check("rw_ld_count", ld_count, 3 + 8);
`else
    // loader ignored in RUN; memory keeps the old word
    ld_valid = 1'b1; ld_addr = 10'd1; ld_data = 32'hdead;
    #1;
    check("run_ld_ignored", ld_ready, 0);
    tick();
    check("run_no_write", im_we, 0);
    check("run_count_hold", ld_count, 3);
    ld_valid = 1'b0;
    fe_req = 1'b1; fe_addr = 10'd1;
    exp_q.push_back(32'h22);
    tick();
    fe_req = 1'b0;
    tick(); tick();
    check("reread_drain", exp_q.size(), 0);
`endif

    // reset one cycle after a fetch grant: the response must vanish
    fe_req = 1'b1; fe_addr = 10'd2;
    tick();
    fe_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_ld_ready", ld_ready, 0);
    check("mid_rst_fe_gnt", fe_gnt, 0);
    tick();
    check("mid_rst_rvalid", fe_rvalid, 0);
    check("mid_rst_im_we", im_we, 0);
    check("mid_rst_im_addr", im_addr, 0);
    check("mid_rst_im_wdata", im_wdata, 0);
    check("mid_rst_boot_done", boot_done, 0);
    check("mid_rst_ld_count", ld_count, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ld_ready", ld_ready, 1);
    tick();
    check("post_rst_rvalid", fe_rvalid, 0);

    // loader beat coinciding with reset is not accepted
    ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'h55; rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    check("rst_beat_im_we", im_we, 0);
    check("rst_beat_count", ld_count, 0);

    // ld_count saturation at 1024
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ld_addr = AW'(i); ld_data = DW'(i);
      tick();
    end
    check("sat_count_full", ld_count, 1024);
    ld_addr = 10'd0; ld_data = 32'h77; ld_last = 1'b1;
    tick();
    idle_inputs();
    check("sat_count_hold", ld_count, 1024);
    check("sat_still_writes", im_we, 1);
    check("sat_wdata", im_wdata, 32'h77);
    check("sat_boot_done", boot_done, 1);
    fe_req = 1'b1; fe_addr = 10'd0;
    exp_q.push_back(32'h77);
    tick();
    fe_req = 1'b0;
    tick(); tick();
    check("sat_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
